// File: rtl/peripheral_display_pkg.sv
// Shared display codes and converter state encoding for the seven-segment front-end.
package peripheral_display_pkg;

  // Must match the special codes decoded by peripheral_deco7seg.
  localparam logic [3:0] DIGIT_BLANK = 4'hF;
  localparam logic [3:0] DIGIT_MINUS = 4'hB;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_t;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble nibble correction: a digit of 5 or more gets +3 before the shift.
module bcd_add3 (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  assign dout = (din >= 4'd5) ? din + 4'd3 : din;

endmodule

// File: rtl/peripheral_bin2digits.sv
// Signed binary to decimal digit codes for the six-digit display, via sequential double-dabble.
module peripheral_bin2digits
  import peripheral_display_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int NUM_DIGITS  = 5,
  parameter int BLANK_ZEROS = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      we,
  input  logic [WIDTH-1:0]          wdata,
  output logic                      busy,
  output logic                      valid,
  output logic [4*(NUM_DIGITS+1)-1:0] digits,
  output state_t                    state_dbg
);

  localparam int BW = 4 * NUM_DIGITS;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [4*(NUM_DIGITS+1)-1:0] DIGITS_RST = {{NUM_DIGITS{DIGIT_BLANK}}, 4'h0};

  // Handshake: we is a single-cycle strobe and is always accepted; writes arriving
  // while a conversion runs land in a one-deep pending slot (newest write wins).
  // valid pulses for one cycle when digits change; busy covers SHIFT, COMMIT and the valid cycle.

  state_t             state;
  logic [CW-1:0]      cnt;
  logic [BW-1:0]      bcd;
  logic [BW-1:0]      bcd_adj;
  logic [WIDTH-1:0]   mag;
  logic               sign_r;
  logic               pend_flag;
  logic [WIDTH-1:0]   pend_data;
  logic               valid_r;
  logic [WIDTH-1:0]   src;
  logic [4*(NUM_DIGITS+1)-1:0] disp;
  logic               seen;
  logic [3:0]         nib;

  genvar g;
  generate
    for (g = 0; g < NUM_DIGITS; g++) begin : g_add3
      bcd_add3 u_add3 (
        .din  (bcd[4*g +: 4]),
        .dout (bcd_adj[4*g +: 4])
      );
    end
  endgenerate

  // A fresh write in the start cycle is newer than anything pending.
  assign src = we ? wdata : pend_data;

  // Leading-zero blanking scans from the most significant magnitude digit down.
  always_comb begin
    disp = '0;
    seen = 1'b0;
    nib  = 4'h0;
    disp[3:0] = bcd[3:0];
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      nib = bcd[4*i +: 4];
      if (nib != 4'h0) seen = 1'b1;
      disp[4*i +: 4] = ((BLANK_ZEROS != 0) && !seen) ? DIGIT_BLANK : nib;
    end
    disp[4*NUM_DIGITS +: 4] = (sign_r && (bcd != '0)) ? DIGIT_MINUS : DIGIT_BLANK;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      bcd       <= '0;
      mag       <= '0;
      sign_r    <= 1'b0;
      pend_flag <= 1'b0;
      pend_data <= '0;
      valid_r   <= 1'b0;
      digits    <= DIGITS_RST;
    end else begin
      valid_r <= 1'b0;
      case (state)
        IDLE: begin
          if (we || pend_flag) begin
            sign_r    <= src[WIDTH-1];
            mag       <= src[WIDTH-1] ? (~src + WIDTH'(1)) : src;
            bcd       <= '0;
            cnt       <= CW'(WIDTH);
            pend_flag <= 1'b0;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          {bcd, mag} <= {bcd_adj[BW-2:0], mag, 1'b0};
          cnt        <= cnt - CW'(1);
          if (cnt == CW'(1)) state <= COMMIT;
        end
        COMMIT: begin
          digits  <= disp;
          valid_r <= 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
      if (we && (state != IDLE)) begin
        pend_flag <= 1'b1;
        pend_data <= wdata;
      end
    end
  end

  assign valid     = valid_r;
  assign busy      = (state != IDLE) || valid_r;
  assign state_dbg = state;

endmodule

// File: tb/tb_peripheral_bin2digits.sv
// Directed and randomized checks of the digit converter against an arithmetic decimal model.
module tb_peripheral_bin2digits;
  import peripheral_display_pkg::*;

  localparam int W  = 16;
  localparam int ND = 5;
  localparam int DW = 4 * (ND + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          we = 1'b0;
  logic [W-1:0]  wdata = '0;
  logic          busy0, valid0, busy1, valid1;
  logic [DW-1:0] digits0, digits1;
  state_t        st0, st1;

  int checks = 0;
  int failures = 0;
  int vcount = 0;
  int cyc = 0;
  int vcyc_q[$];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] exp_q_nb[$];

  peripheral_bin2digits #(.WIDTH(W), .NUM_DIGITS(ND), .BLANK_ZEROS(1)) dut (
    .clk(clk), .reset(rst), .we(we), .wdata(wdata),
    .busy(busy0), .valid(valid0), .digits(digits0), .state_dbg(st0)
  );

  peripheral_bin2digits #(.WIDTH(W), .NUM_DIGITS(ND), .BLANK_ZEROS(0)) dut_nb (
    .clk(clk), .reset(rst), .we(we), .wdata(wdata),
    .busy(busy1), .valid(valid1), .digits(digits1), .state_dbg(st1)
  );

  // clock / watchdog
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Decimal reference: digits by repeated division, blanking by magnitude < 10^i.
  function automatic logic [DW-1:0] model(input logic [W-1:0] v, input bit blank);
    logic [DW-1:0] r;
    int m, t, p;
    bit s;
    s = v[W-1];
    m = s ? (65536 - int'(v)) : int'(v);
    t = m;
    p = 1;
    r = '0;
    for (int i = 0; i < ND; i++) begin
      if (blank && i >= 1 && m < p) r[4*i +: 4] = 4'hF;
      else r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
      p = p * 10;
    end
    r[4*ND +: 4] = (s && m != 0) ? 4'hB : 4'hF;
    return r;
  endfunction

  // scoreboard: every valid pulse pops the next expected display
  always @(negedge clk) begin
    if (!rst && valid0) begin
      vcount++;
      vcyc_q.push_back(cyc);
      if (exp_q.size() == 0) check("unexpected_valid", 32'(digits0), 32'hDEAD);
      else check("digits_blank", 32'(digits0), 32'(exp_q.pop_front()));
    end
    if (!rst && valid1) begin
      if (exp_q_nb.size() == 0) check("unexpected_valid_nb", 32'(digits1), 32'hDEAD);
      else check("digits_noblank", 32'(digits1), 32'(exp_q_nb.pop_front()));
    end
  end

  // driver tasks
  task automatic write(input logic [W-1:0] v);
    @(negedge clk);
    we = 1'b1;
    wdata = v;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic expect_val(input logic [W-1:0] v);
    exp_q.push_back(model(v, 1'b1));
    exp_q_nb.push_back(model(v, 1'b0));
  endtask

  task automatic wait_valids(input int n, input int budget);
    int start;
    start = vcount;
    for (int i = 0; i < budget && vcount < start + n; i++) @(posedge clk);
    check("valid_wait", 32'(vcount - start), 32'(n));
  endtask

  initial begin
    logic [W-1:0] v;
    int base;

    // reset state
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_digits", 32'(digits0), 32'hFFFFF0);
    check("rst_busy", 32'(busy0), 32'h0);
    repeat (10) @(negedge clk);
    check("idle_digits", 32'(digits0), 32'hFFFFF0);
    check("idle_valid_count", 32'(vcount), 32'h0);

    // 12345 with cycle-exact latency
    expect_val(16'h3039);
    write(16'h3039);
    check("busy_after_we", 32'(busy0), 32'h1);
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      check($sformatf("lat_valid_e%0d", k), 32'(valid0), 32'(k == 17));
    end
    check("busy_in_valid", 32'(busy0), 32'h1);
    check("digits_12345", 32'(digits0), 32'hF12345);
    @(negedge clk);
    check("busy_after_valid", 32'(busy0), 32'h0);
    check("valid_one_cycle", 32'(valid0), 32'h0);

    // negative values and zero after a negative
    expect_val(16'hFFFF);
    write(16'hFFFF);
    wait_valids(1, 40);
    expect_val(16'h8000);
    write(16'h8000);
    wait_valids(1, 40);
    @(negedge clk);
    check("digits_m32768", 32'(digits0), 32'hB32768);
    expect_val(16'h0000);
    write(16'h0000);
    wait_valids(1, 40);
    @(negedge clk);
    check("digits_zero", 32'(digits0), 32'hFFFFF0);
    check("digits_zero_nb", 32'(digits1), 32'hF00000);

    // writes while busy: 9 is overwritten by 42
    base = vcount;
    vcyc_q.delete();
    expect_val(16'd7);
    expect_val(16'd42);
    write(16'd7);
    @(negedge clk);
    write(16'd9);
    write(16'd42);
    wait_valids(2, 80);
    repeat (30) @(negedge clk);
    check("pending_pulses", 32'(vcount - base), 32'h2);
    check("pending_digits", 32'(digits0), 32'hFFFF42);
    if (vcyc_q.size() == 2) check("pending_gap", 32'(vcyc_q[1] - vcyc_q[0]), 32'd18);
    else check("pending_gap_count", 32'(vcyc_q.size()), 32'h2);

    // randomized values, some back-to-back with the pending slot
    for (int n = 0; n < 24; n++) begin
      v = W'($urandom);
      expect_val(v);
      write(v);
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(0, 12)) @(negedge clk);
        v = W'($urandom);
        expect_val(v);
        write(v);
        wait_valids(2, 80);
      end else begin
        wait_valids(1, 40);
      end
    end
    repeat (3) @(negedge clk);

    // reset mid-conversion aborts with no valid
    base = vcount;
    write(16'h3039);
    write(16'h0011);
    repeat (6) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_digits", 32'(digits0), 32'hFFFFF0);
    check("abort_busy", 32'(busy0), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (60) @(negedge clk);
    check("abort_no_valid", 32'(vcount - base), 32'h0);
    check("abort_no_restart", 32'(busy0), 32'h0);
    check("abort_digits_hold", 32'(digits0), 32'hFFFFF0);

    check("exp_q_drained", 32'(exp_q.size()), 32'h0);
    check("exp_q_nb_drained", 32'(exp_q_nb.size()), 32'h0);

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
